// File: rtl/rgb_proto_pkg.sv
// rgb_proto_pkg: shared state codes, bit timing default, length codes and CHECK helper for the RGB frame link
package rgb_proto_pkg;
  localparam int DEF_CLKS_PER_BIT = 101;
  localparam logic [7:0] LEN_R = 8'd1;
  localparam logic [7:0] LEN_RG = 8'd2;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_CMD = 4'd2;
  localparam logic [3:0] ST_LENGTH = 4'd3;
  localparam logic [3:0] ST_R = 4'd4;
  localparam logic [3:0] ST_G = 4'd5;
  localparam logic [3:0] ST_B = 4'd6;
  localparam logic [3:0] ST_CHECK = 4'd7;
  localparam logic [3:0] ST_STOP = 4'd8;
  localparam logic [3:0] ST_CLEANUP = 4'd9;
  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_START = ST_START,
    S_CMD = ST_CMD,
    S_LEN = ST_LENGTH,
    S_R = ST_R,
    S_G = ST_G,
    S_B = ST_B,
    S_CHECK = ST_CHECK,
    S_STOP = ST_STOP,
    S_CLEANUP = ST_CLEANUP
  } state_e;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] chk;
  } frame_t;
  function automatic logic [7:0] calc_check(input logic [7:0] cmd, input logic [7:0] len,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    return cmd ^ len ^ r ^ (len != LEN_R ? g : 8'h00) ^
           (len != LEN_R && len != LEN_RG ? b : 8'h00);
  endfunction
endpackage

// File: rtl/rgb_tx_bit_timer.sv
// rgb_tx_bit_timer: counts 0..CLKS_PER_BIT-1 while enabled and ticks bit_end on the last cycle of each bit
module rgb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 101
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = en && cnt_q == LAST;
  always_comb cnt_d = clr || bit_end ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/rgb_frame_tx.sv
// rgb_frame_tx: single-wire RGB frame serializer (start, CMD, LENGTH, R[,G[,B]], CHECK, stop; LSB first); RGB_TX_AUTO_CHECK_EN derives CHECK from the latched bytes
module rgb_frame_tx
  import rgb_proto_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd_in,
  input  logic [7:0] length_in,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic [7:0] check_in,
  output logic       data_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] state
);
  state_e state_q, state_d, nxt;
  frame_t frm_q, frm_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] cur, in_chk;
  logic data_out_q, data_out_d, busy_q, busy_d, done_q, done_d;
  logic load, bit_end, byte_st;
`ifdef RGB_TX_AUTO_CHECK_EN
  logic unused_check_in;
  assign unused_check_in = ^check_in;
  assign in_chk = calc_check(cmd_in, length_in, r_in, g_in, b_in);
`else
  assign in_chk = check_in;
`endif
  assign load = state_q == S_IDLE && start;
  rgb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(state_q != S_IDLE && state_q != S_CLEANUP),
    .clr(load),
    .bit_end(bit_end)
  );
  always_comb begin
    frm_d = load ? frame_t'{cmd: cmd_in, len: length_in, r: r_in, g: g_in, b: b_in, chk: in_chk} : frm_q;
    byte_st = state_q inside {S_CMD, S_LEN, S_R, S_G, S_B, S_CHECK};
    nxt = S_IDLE;
    case (state_q)
      S_START: nxt = S_CMD;
      S_CMD:   nxt = S_LEN;
      S_LEN:   nxt = S_R;
      S_R:     nxt = frm_q.len == LEN_R ? S_CHECK : S_G;
      S_G:     nxt = frm_q.len == LEN_RG ? S_CHECK : S_B;
      S_B:     nxt = S_CHECK;
      S_CHECK: nxt = S_STOP;
      S_STOP:  nxt = S_CLEANUP;
      default: nxt = S_IDLE;
    endcase
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      state_d = S_START;
      bit_idx_d = '0;
    end else if (state_q == S_CLEANUP) begin
      state_d = S_IDLE;
    end else if (bit_end) begin
      bit_idx_d = byte_st ? bit_idx_q + 3'd1 : 3'd0;
      state_d = byte_st && bit_idx_q != 3'd7 ? state_q : nxt;
    end
    cur = 8'hFF;
    case (state_d)
      S_START: cur = 8'h00;
      S_CMD:   cur = frm_d.cmd;
      S_LEN:   cur = frm_d.len;
      S_R:     cur = frm_d.r;
      S_G:     cur = frm_d.g;
      S_B:     cur = frm_d.b;
      S_CHECK: cur = frm_d.chk;
      default: cur = 8'hFF;
    endcase
    data_out_d = cur[bit_idx_d];
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_CLEANUP;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      frm_q <= '0;
      bit_idx_q <= '0;
      data_out_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frm_q <= frm_d;
      bit_idx_q <= bit_idx_d;
      data_out_q <= data_out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign data_out = data_out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign state = state_q;
endmodule

// File: tb/tb_rgb_frame_tx.sv
// tb_rgb_frame_tx: table, random and corner-case checks of the decoded line against a byte-list model
module tb_rgb_frame_tx;
  localparam int CPB = 101;
`ifdef RGB_TX_AUTO_CHECK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] c, l, r, g, b, k;
    int n;
    logic [7:0] ca, cm;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] cmd_in = '0, length_in = '0, r_in = '0, g_in = '0, b_in = '0, check_in = '0;
  logic data_out, busy, done;
  logic [3:0] state;
  int tests = 0, fails = 0;
  vec_t tbl[5];
  always #5 clk = ~clk;
  rgb_frame_tx dut (
    .clk(clk), .reset(reset), .start(start), .cmd_in(cmd_in), .length_in(length_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .check_in(check_in),
    .data_out(data_out), .busy(busy), .done(done), .state(state)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  function automatic bq_t model(input logic [7:0] c, l, r, g, b, k);
    bq_t q;
    logic [7:0] x;
    q = '{c, l, r};
    if (l != 8'd1) q.push_back(g);
    if (l != 8'd1 && l != 8'd2) q.push_back(b);
    x = '0;
    foreach (q[i]) x ^= q[i];
    q.push_back(AUTO ? x : k);
    return q;
  endfunction
  task automatic launch(input logic [7:0] c, l, r, g, b, k, input bit keep);
    @(posedge clk); #1;
    cmd_in = c; length_in = l; r_in = r; g_in = g; b_in = b; check_in = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = keep;
    cmd_in = 8'($urandom); length_in = 8'($urandom); r_in = 8'($urandom);
    g_in = 8'($urandom); b_in = 8'($urandom); check_in = 8'($urandom);
  endtask
  task automatic capture(input string name, input bq_t exp, input int repulse);
    logic q[$];
    bit s5, s6, uni;
    int c, nb;
    logic [7:0] got;
    nb = exp.size();
    s5 = 0; s6 = 0; c = 0;
    check({name, " launch"}, {state, busy, data_out}, {4'd1, 1'b1, 1'b0});
    while (busy && !done && c < 6000) begin
      q.push_back(data_out);
      s5 |= state == 4'd5;
      s6 |= state == 4'd6;
      if (repulse >= 0 && c == repulse) begin
        start = 1'b1; cmd_in = 8'($urandom); length_in = 8'd3; r_in = 8'($urandom);
      end
      if (repulse >= 0 && c == repulse + 1) start = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    check({name, " done"}, done, 1'b1);
    check({name, " cycles"}, q.size(), (8 * nb + 2) * CPB);
    if (q.size() == (8 * nb + 2) * CPB) begin
      uni = 1;
      for (int i = 0; i < q.size(); i++) if (q[i] !== q[(i / CPB) * CPB]) uni = 0;
      check({name, " bit width"}, uni, 1'b1);
      check({name, " start bit"}, q[CPB / 2], 1'b0);
      for (int k = 0; k < nb; k++) begin
        for (int b = 0; b < 8; b++) got[b] = q[(1 + 8 * k + b) * CPB + CPB / 2];
        check($sformatf("%s byte%0d", name, k), got, exp[k]);
      end
      check({name, " stop bit"}, q[(8 * nb + 1) * CPB + CPB / 2], 1'b1);
    end
    check({name, " G/B visits"}, {s6, s5}, {nb == 6, nb >= 5});
    @(posedge clk); #1;
    check({name, " done fall"}, {done, busy, state, data_out}, {1'b0, 1'b0, 4'd0, 1'b1});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bq_t e, e2;
    int c;
    logic [7:0] rc, rl, rr, rg, rb, rk;
    tbl[0] = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h77, 3, 8'hD6, 8'h77};
    tbl[1] = '{8'h01, 8'h01, 8'hFF, 8'hAA, 8'hBB, 8'h00, 1, 8'hFF, 8'h00};
    tbl[2] = '{8'h10, 8'h02, 8'h20, 8'h40, 8'h80, 8'h3C, 2, 8'h72, 8'h3C};
    tbl[3] = '{8'h55, 8'h00, 8'h11, 8'h22, 8'h44, 8'h99, 3, 8'h22, 8'h99};
    tbl[4] = '{8'hC3, 8'h07, 8'h01, 8'h02, 8'h04, 8'h5A, 3, 8'hC3, 8'h5A};
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {data_out, busy, done, state}, {1'b1, 1'b0, 1'b0, 4'd0});
    reset = 1'b1;
    foreach (tbl[i]) begin
      e = '{tbl[i].c, tbl[i].l, tbl[i].r};
      if (tbl[i].n >= 2) e.push_back(tbl[i].g);
      if (tbl[i].n == 3) e.push_back(tbl[i].b);
      e.push_back(AUTO ? tbl[i].ca : tbl[i].cm);
      launch(tbl[i].c, tbl[i].l, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].k, 1'b0);
      capture($sformatf("vec%0d", i), e, -1);
    end
    for (int i = 0; i < 4; i++) begin
      rc = 8'($urandom); rr = 8'($urandom); rg = 8'($urandom);
      rb = 8'($urandom); rk = 8'($urandom);
      rl = i < 3 ? 8'(i + 1) : 8'($urandom);
      e = model(rc, rl, rr, rg, rb, rk);
      launch(rc, rl, rr, rg, rb, rk, 1'b0);
      capture($sformatf("rand%0d", i), e, -1);
    end
    e = model(8'h6B, 8'h01, 8'h9E, 8'h00, 8'h00, 8'h4D);
    launch(8'h6B, 8'h01, 8'h9E, 8'h00, 8'h00, 8'h4D, 1'b0);
    capture("repulse", e, 500);
    repeat (5) @(posedge clk);
    #1;
    check("no second frame", {busy, state}, {1'b0, 4'd0});
    e = model(8'h3A, 8'h01, 8'hC4, 8'h00, 8'h00, 8'h21);
    e2 = model(8'h81, 8'h02, 8'h18, 8'hE7, 8'h00, 8'h5F);
    launch(8'h3A, 8'h01, 8'hC4, 8'h00, 8'h00, 8'h21, 1'b1);
    cmd_in = 8'h81; length_in = 8'h02; r_in = 8'h18; g_in = 8'hE7; b_in = 8'h00; check_in = 8'h5F;
    capture("holdA", e, -1);
    @(posedge clk); #1;
    start = 1'b0;
    capture("holdB", e2, -1);
    launch(8'hF0, 8'h03, 8'h0F, 8'h5A, 8'hA5, 8'h00, 1'b0);
    c = 0;
    while (state != 4'd5 && c < 6000) begin
      @(posedge clk); #1;
      c++;
    end
    check("reach SEND_G", state, 4'd5);
    repeat (3 * CPB + 20) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid-frame reset", {data_out, state, busy, done}, {1'b1, 4'd0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("reset no done", {done, busy}, 2'b00);
    reset = 1'b1;
    e = model(8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h77);
    launch(8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h77, 1'b0);
    capture("after reset", e, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
